// File: rtl/braille_dot_driver.sv
// Sequential coil driver for an 8-pin bistable braille cell: pulses only the
// dots that differ from what the cell shows, one coil at a time, ascending.
module braille_dot_driver #(
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cell_in,
  output logic [7:0] dot_set,
  output logic [7:0] dot_clr,
  output logic [7:0] dots_shown,
  output logic       busy,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_target;
  logic [2:0]  r_idx;
  logic [15:0] r_cnt;
  logic [7:0]  r_shown;
  logic [7:0]  r_dot_set;
  logic [7:0]  r_dot_clr;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_next;
  logic [7:0]  w_target_next;
  logic [2:0]  w_idx_next;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_shown_next;
  logic [7:0]  w_set_next;
  logic [7:0]  w_clr_next;
  logic        w_busy_next;
  logic        w_done_next;
  logic [7:0]  w_bit_mask;
  logic        w_dot_differs;

  assign w_bit_mask    = 8'(1 << r_idx);
  assign w_dot_differs = r_target[r_idx] != r_shown[r_idx];

  // State register. Reset lands in SCAN with shown=FF and target=00 so the
  // first pass clears every pin, since the physical cell state is unknown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_SCAN;
      r_target  <= 8'h00;
      r_idx     <= 3'd0;
      r_cnt     <= 16'd0;
      r_shown   <= 8'hFF;
      r_dot_set <= 8'h00;
      r_dot_clr <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_target  <= w_target_next;
      r_idx     <= w_idx_next;
      r_cnt     <= w_cnt_next;
      r_shown   <= w_shown_next;
      r_dot_set <= w_set_next;
      r_dot_clr <= w_clr_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic; cell_in is only looked at from IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_idx_next    = r_idx;
    w_cnt_next    = r_cnt;
    w_shown_next  = r_shown;
    case (r_state)
      S_IDLE: begin
        if (cell_in != r_shown) begin
          w_target_next = cell_in;
          w_idx_next    = 3'd0;
          w_state_next  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_dot_differs) begin
          w_cnt_next   = 16'd0;
          w_state_next = S_PULSE;
        end else if (r_idx == 3'd7) begin
          w_state_next = S_DONE;
        end else begin
          w_idx_next = r_idx + 3'd1;
        end
      end
      S_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_shown_next[r_idx] = r_target[r_idx];
          w_cnt_next          = 16'd0;
          w_state_next        = S_GAP;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (r_idx == 3'd7) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_state_next = S_SCAN;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so coil drive
  // is glitch-free and aligned with the cycles the FSM spends in PULSE.
  always_comb begin
    w_set_next  = 8'h00;
    w_clr_next  = 8'h00;
    w_busy_next = w_state_next != S_IDLE;
    w_done_next = w_state_next == S_DONE;
    if (w_state_next == S_PULSE) begin
      if (r_target[r_idx]) begin
        w_set_next = w_bit_mask;
      end else begin
        w_clr_next = w_bit_mask;
      end
    end
  end

  assign dot_set     = r_dot_set;
  assign dot_clr     = r_dot_clr;
  assign dots_shown  = r_shown;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_braille_dot_driver.sv
// Bench for braille_dot_driver: a per-cycle timeline model built from the
// pass rules, checked every cycle, plus hand-computed literal expectations.
module tb_braille_dot_driver;
  localparam int P = 4;
  localparam int G = 2;
  localparam int W = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cell_in;
  logic [7:0] dot_set;
  logic [7:0] dot_clr;
  logic [7:0] dots_shown;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  braille_dot_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .cell_in    (cell_in),
    .dot_set    (dot_set),
    .dot_clr    (dot_clr),
    .dots_shown (dots_shown),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: expected entries {busy, done, dot_set, dot_clr, dots_shown}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_now;
  logic [7:0]   m_shown;
  logic         m_last_done = 1'b0;
  logic         m_valid = 1'b0;

  function automatic logic [W-1:0] pack(logic b, logic d, logic [7:0] s, logic [7:0] c, logic [7:0] sh);
    return {b, d, s, c, sh};
  endfunction

  // Whole pass as a cycle timeline: each dot costs one scan cycle, plus P drive
  // cycles and G quiet cycles if it changes; the new bit shows from the first
  // quiet cycle; one done cycle closes the pass.
  function automatic void gen_pass(logic [7:0] from_v, logic [7:0] to_v);
    logic [7:0] cur;
    logic [7:0] m;
    cur = from_v;
    for (int i = 0; i < 8; i++) begin
      m = 8'(1 << i);
      exp_q.push_back(pack(1'b1, 1'b0, 8'h00, 8'h00, cur));
      if (cur[i] != to_v[i]) begin
        for (int k = 0; k < P; k++)
          exp_q.push_back(pack(1'b1, 1'b0, to_v[i] ? m : 8'h00, to_v[i] ? 8'h00 : m, cur));
        cur[i] = to_v[i];
        for (int k = 0; k < G; k++)
          exp_q.push_back(pack(1'b1, 1'b0, 8'h00, 8'h00, cur));
      end
    end
    exp_q.push_back(pack(1'b1, 1'b1, 8'h00, 8'h00, cur));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      gen_pass(8'hFF, 8'h00);
      exp_now = exp_q.pop_front();
      exp_now[W-1] = 1'b0;
      m_last_done = 1'b0;
    end else if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      m_last_done = exp_now[W-2];
    end else if (!m_last_done && cell_in != m_shown) begin
      gen_pass(m_shown, cell_in);
      exp_now = exp_q.pop_front();
    end else begin
      exp_now = pack(1'b0, 1'b0, 8'h00, 8'h00, m_shown);
      m_last_done = 1'b0;
    end
    m_shown = exp_now[7:0];
    m_valid = 1'b1;
  end

  // Per-cycle compare and pulse-start log
  logic [15:0] pulse_log[$];
  logic [15:0] want_q[$];
  logic [15:0] prev_bus = 16'h0000;

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy",       {31'd0, busy}, {31'd0, exp_now[25]});
      check("done",       {31'd0, done}, {31'd0, exp_now[24]});
      check("dot_set",    {24'd0, dot_set}, {24'd0, exp_now[23:16]});
      check("dot_clr",    {24'd0, dot_clr}, {24'd0, exp_now[15:8]});
      check("dots_shown", {24'd0, dots_shown}, {24'd0, exp_now[7:0]});
      check("set_clr_overlap", {24'd0, dot_set & dot_clr}, 32'd0);
      check("one_coil", ($countones({dot_set, dot_clr}) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if ({dot_set, dot_clr} != 16'h0000 && prev_bus == 16'h0000)
        pulse_log.push_back({dot_set, dot_clr});
      prev_bus = {dot_set, dot_clr};
    end
  end

  // Driver tasks
  task automatic drive(input logic [7:0] v, output int c0);
    @(posedge clk);
    #2;
    cell_in = v;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, pulse_log.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < pulse_log.size(); i++)
      check(name, {16'd0, pulse_log[i]}, {16'd0, want_q[i]});
  endtask

  task automatic load_init_walk();
    want_q.delete();
    for (int i = 0; i < 8; i++) want_q.push_back({8'h00, 8'(1 << i)});
  endtask

  initial begin
    int c0;
    int cd;
    int seen;
    int act;
    reset = 1'b1;
    cell_in = 8'h00;

    // Init clear pass after reset
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    c0 = cyc;
    pulse_log.delete();
    wait_done(200, cd);
    check("init_done_cycle", cd - c0 + 1, 32'd57);
    load_init_walk();
    check_log("init_pulses");
    @(negedge clk);
    check("init_busy_after", {31'd0, busy}, 32'd0);
    check("init_shown", {24'd0, dots_shown}, 32'h00);

    // Single dot set
    pulse_log.delete();
    drive(8'h01, c0);
    @(negedge clk);
    check("t2_busy_before", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t2_busy_rise", {31'd0, busy}, 32'd1);
    wait_done(100, cd);
    check("t2_done_latency", cd - c0, 32'd15);
    check("t2_shown", {24'd0, dots_shown}, 32'h01);
    want_q.delete();
    want_q.push_back({8'h01, 8'h00});
    check_log("t2_pulses");

    // 0x0F -> 0xF0: all eight dots, ascending order
    drive(8'h0F, c0);
    wait_done(200, cd);
    pulse_log.delete();
    drive(8'hF0, c0);
    wait_done(300, cd);
    check("t3_shown", {24'd0, dots_shown}, 32'hF0);
    want_q.delete();
    want_q.push_back({8'h00, 8'h01});
    want_q.push_back({8'h00, 8'h02});
    want_q.push_back({8'h00, 8'h04});
    want_q.push_back({8'h00, 8'h08});
    want_q.push_back({8'h10, 8'h00});
    want_q.push_back({8'h20, 8'h00});
    want_q.push_back({8'h40, 8'h00});
    want_q.push_back({8'h80, 8'h00});
    check_log("t3_pulses");

    // Request changes during the first pulse of a pass
    drive(8'h03, c0);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if ((dot_set | dot_clr) != 8'h00) seen = 1;
    end
    check("t4_pulse_seen", seen, 32'd1);
    cell_in = 8'h3C;
    wait_done(300, cd);
    check("t4_first_shown", {24'd0, dots_shown}, 32'h03);
    @(negedge clk);
    check("t4_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t4_rebusy", {31'd0, busy}, 32'd1);
    wait_done(300, cd);
    check("t4_final_shown", {24'd0, dots_shown}, 32'h3C);

    // Reset in the middle of a dot_set=0x04 pulse
    drive(8'h00, c0);
    wait_done(300, cd);
    drive(8'h04, c0);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (dot_set == 8'h04) seen = 1;
    end
    check("t5_set4_seen", seen, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cell_in = 8'h00;
    @(posedge clk);
    #2;
    reset = 1'b0;
    c0 = cyc;
    pulse_log.delete();
    @(negedge clk);
    check("t5_bus_zero", {16'd0, dot_set, dot_clr}, 32'd0);
    wait_done(200, cd);
    check("t5_done_cycle", cd - c0 + 1, 32'd57);
    load_init_walk();
    check_log("t5_pulses");
    check("t5_shown", {24'd0, dots_shown}, 32'h00);

    // Matching request in IDLE stays quiet
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || dot_set != 8'h00 || dot_clr != 8'h00) act++;
    end
    check("idle_quiet", act, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/braille_dot_driver.md
# braille_dot_driver

Downstream stage of `braille_converter_top`. It consumes the 8-bit dot pattern on `reader1_out` and physically renders it on a cell of 8 bistable (latching) solenoid pins. Each pin flips only on a timed set or clear coil pulse. To cap peak supply current, at most one coil is energized at any time: the block scans the dots and pulses only the dots that must change, with a dead gap after each pulse. It also tracks what the cell currently shows.

## Interface
Parameters:
- `PULSE_CYCLES`, default 16: coil on-time per dot in clocks; legal range 1..65535.
- `GAP_CYCLES`, default 4: all-coils-off dead time after each pulse; legal range 1..65535.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `cell_in`  in  8  requested dot pattern (bit i = dot i+1, 1 = raised), driven by `reader1_out`.
- `dot_set`  out  8  one-hot or zero set-coil drive; registered.
- `dot_clr`  out  8  one-hot or zero clear-coil drive; registered.
- `dots_shown`  out  8  pattern currently latched on the physical cell.
- `busy`  out  1  high while a refresh or init pass is in progress.
- `done`  out  1  single-cycle pulse when a pass completes.

## Operation
- The FSM has 5 states: IDLE, SCAN, PULSE, GAP, DONE.
- Internal registers:
  - `target[7:0]`: pattern being rendered.
  - `idx[2:0]`: dot currently being scanned.
  - `cnt[15:0]`: pulse/gap counter.
  - `shown[7:0]`: drives `dots_shown`.
- Reset, while `reset` is high: `dot_set=0`, `dot_clr=0`, `busy=0`, `done=0`, `shown=8'hFF`, `target=8'h00`, `idx=0`, state=SCAN.
  - The first pass after reset is therefore a clear-all init pass: every dot gets a clear pulse, since the physical cell state is unknown.
- IDLE: `busy=0`.
  - If `cell_in != shown`: `target<=cell_in`, `idx<=0`, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (one cycle per dot):
  - If `target[idx] != shown[idx]`, go to PULSE with `cnt<=0`.
  - Else if `idx==7`, go to DONE.
  - Else `idx<=idx+1` and stay in SCAN.
- PULSE:
  - `dot_set=(1<<idx)` if `target[idx]=1`; otherwise `dot_clr=(1<<idx)`.
  - Lasts exactly `PULSE_CYCLES` cycles.
  - On leaving: `shown[idx]<=target[idx]`, `cnt<=0`, go to GAP.
- GAP: both drive buses are 0 for exactly `GAP_CYCLES` cycles.
  - Then if `idx==7`, go to DONE; else `idx<=idx+1`, go to SCAN.
- DONE: `done=1` for one cycle, then go to IDLE.
- `busy=1` in SCAN, PULSE, GAP and DONE.
- Invariants:
  - `dot_set & dot_clr == 0` always.
  - `popcount(dot_set|dot_clr) <= 1` always.
  - Both buses are 0 in every non-PULSE cycle.
- `cell_in` is sampled only in IDLE. Changes during a pass are ignored. The new value is picked up by the IDLE compare after DONE, so the last request always wins.
- Rendering order is ascending dot index. Unchanged dots cost one SCAN cycle and no pulse.
- A reset asserted mid-pass, including mid-PULSE, drops both coil buses to 0 on the next edge and restarts the init clear pass.

## Timing
- Drive outputs are registered: they rise on the first cycle the FSM is in PULSE and fall on the first GAP cycle.
- IDLE sees a mismatch at edge k. SCAN starts at k+1, and `busy` is high from k+1.
- Per changed dot: 1 SCAN + `PULSE_CYCLES` + `GAP_CYCLES` cycles. Per unchanged dot: 1 cycle.
- Pass length from the first SCAN cycle to DONE inclusive = 8 + n·(`PULSE_CYCLES`+`GAP_CYCLES`) + 1, where n = number of changed dots.
- The init pass after reset release has n=8: 8 + 8·(P+G) + 1 cycles, followed by `done`.
- `dots_shown` updates on the cycle PULSE ends, i.e. the first GAP cycle shows the new bit.
- `busy` falls the cycle after `done`.

## Test plan
- Reset init pass with P=4, G=2, `cell_in=0`:
  - `dot_clr` walks 0x01, 0x02, … 0x80, each high exactly 4 cycles with 2 zero cycles between.
  - `dot_set` stays 0.
  - `done` pulses at cycle 57 after release, then `busy=0` and `dots_shown=0x00`.
- From idle with `dots_shown=0x00`, drive `cell_in=0x01`:
  - `busy` rises 1 cycle later, then `dot_set=0x01` for 4 cycles.
  - `done` at 15 cycles after the change was sampled; `dots_shown=0x01`.
- From `dots_shown=0x0F`, drive `cell_in=0xF0`:
  - 8 pulses in order: `dot_clr` 0x01, 0x02, 0x04, 0x08, then `dot_set` 0x10, 0x20, 0x40, 0x80.
  - Final `dots_shown=0xF0`.
- Change `cell_in` from 0x03 to 0x3C while the 0x03 pass is in its first PULSE:
  - 0x03 completes, with `done` firing.
  - `busy` drops for exactly 1 IDLE cycle.
  - A second pass renders 0x3C, ending with `dots_shown=0x3C`.
- Assert `reset` for 1 cycle in the middle of a `dot_set=0x04` pulse:
  - Both buses are 0 on the next edge.
  - The init clear-all pass reruns.
- Throughout every test, assert each cycle:
  - `dot_set & dot_clr == 0`.
  - At most 1 bit high across both buses.
  - `cell_in==dots_shown` in IDLE produces no activity.
